pll_reconfig_ctrl: RTL and testbench

Sequencer for the Gowin rPLL's dynamic divider ports (IDSEL/FBDSEL/ODSEL) and its RESET input. It brings the PLL up at power-on, applies divider changes requested by a host (CPU register block), and waits for a qualified LOCK. It gates downstream clock use through `clk_en` until lock is stable, and recovers automatically from lock loss. It runs on the free-running board clock, never on a PLL output.

---
 rtl/pll_reconfig_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_pll_reconfig_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl: sequences the rPLL dynamic divider selects and RESET.
// It brings the PLL up after reset, applies host divider changes, qualifies
// LOCK and gates downstream clock use through clk_en. Runs on the board clock.
//
// Handshake: req is a level held by the host until ack. It is accepted only
// in RUN (with lock_s high) or FAIL; ack is a one-cycle pulse at the end of
// that request's sequence, with error valid on the same edge.
module pll_reconfig_ctrl #(
  parameter logic [5:0] DEF_IDSEL    = 6'd8,
  parameter logic [5:0] DEF_FBDSEL   = 6'd15,
  parameter logic [5:0] DEF_ODSEL    = 6'd16,
  parameter int         RST_CYCLES   = 16,
  parameter int         LOCK_TIMEOUT = 65535,
  parameter int         LOCK_STABLE  = 256,
  parameter int         GATE_CYCLES  = 4,
  parameter int         MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [5:0] cfg_idsel,
  input  logic [5:0] cfg_fbdsel,
  input  logic [5:0] cfg_odsel,
  output logic       ack,
  output logic       error,
  output logic       busy,
  output logic       clk_en,
  output logic       lock_lost,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [5:0] pll_odsel
);

  typedef enum logic [2:0] {
    GATE      = 3'd0,
    PLL_RST   = 3'd1,
    WAIT_LOCK = 3'd2,
    STABLE    = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5
  } state_t;

  localparam logic [15:0] GATE_LAST   = 16'(GATE_CYCLES - 1);
  localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
  localparam logic [15:0] TMO_LAST    = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE - 1);
  localparam logic [7:0]  RETRY_MAX   = 8'(MAX_RETRY);

  state_t      state;
  logic [1:0]  lock_sync;
  logic        lock_s;
  logic [15:0] cnt;      // phase counter shared by GATE, PLL_RST and STABLE
  logic [15:0] tmo;      // lock timeout, kept across STABLE->WAIT_LOCK bounces
  logic [7:0]  retry;
  logic        pending;  // current sequence was started by a host request
  logic [5:0]  lat_idsel;
  logic [5:0]  lat_fbdsel;
  logic [5:0]  lat_odsel;
  logic        accept;

  assign lock_s = lock_sync[1];

  // Lock loss in RUN takes priority over a simultaneous request.
  assign accept = req && ((state == RUN && lock_s) || state == FAIL);

  // Two-flop synchronizer for the asynchronous rPLL LOCK.
  always_ff @(posedge clk) begin
    if (reset) lock_sync <= 2'b00;
    else       lock_sync <= {lock_sync[0], pll_lock};
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= PLL_RST;
      cnt        <= '0;
      tmo        <= '0;
      retry      <= '0;
      pending    <= 1'b0;
      ack        <= 1'b0;
      error      <= 1'b0;
      busy       <= 1'b1;
      clk_en     <= 1'b0;
      lock_lost  <= 1'b0;
      pll_reset  <= 1'b1;
      pll_idsel  <= DEF_IDSEL;
      pll_fbdsel <= DEF_FBDSEL;
      pll_odsel  <= DEF_ODSEL;
      lat_idsel  <= DEF_IDSEL;
      lat_fbdsel <= DEF_FBDSEL;
      lat_odsel  <= DEF_ODSEL;
    end else begin
      ack <= 1'b0;
      if (accept) begin
        lat_idsel  <= cfg_idsel;
        lat_fbdsel <= cfg_fbdsel;
        lat_odsel  <= cfg_odsel;
        pending    <= 1'b1;
        error      <= 1'b0;
        lock_lost  <= 1'b0;
        retry      <= '0;
        busy       <= 1'b1;
        clk_en     <= 1'b0;
        cnt        <= '0;
        state      <= GATE;
      end else begin
        case (state)
          GATE: begin
            if (cnt == GATE_LAST) begin
              state      <= PLL_RST;
              pll_reset  <= 1'b1;
              pll_idsel  <= lat_idsel;
              pll_fbdsel <= lat_fbdsel;
              pll_odsel  <= lat_odsel;
              cnt        <= '0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          PLL_RST: begin
            if (cnt == RST_LAST) begin
              state     <= WAIT_LOCK;
              pll_reset <= 1'b0;
              tmo       <= '0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          WAIT_LOCK: begin
            if (lock_s) begin
              // This sampled lock cycle already counts toward stability.
              state <= STABLE;
              cnt   <= 16'd1;
            end else if (tmo == TMO_LAST) begin
              cnt       <= '0;
              pll_reset <= 1'b1;
              if (retry < RETRY_MAX) begin
                retry <= retry + 8'd1;
                state <= PLL_RST;
              end else begin
                state   <= FAIL;
                error   <= 1'b1;
                busy    <= 1'b0;
                ack     <= pending;
                pending <= 1'b0;
              end
            end else begin
              tmo <= tmo + 16'd1;
            end
          end
          STABLE: begin
            if (!lock_s) begin
              state <= WAIT_LOCK;
            end else if (cnt == STABLE_LAST) begin
              state   <= RUN;
              clk_en  <= 1'b1;
              busy    <= 1'b0;
              ack     <= pending;
              pending <= 1'b0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          RUN: begin
            if (!lock_s) begin
              state     <= PLL_RST;
              lock_lost <= 1'b1;
              clk_en    <= 1'b0;
              busy      <= 1'b1;
              pll_reset <= 1'b1;
              retry     <= '0;
              cnt       <= '0;
            end
          end
          FAIL: begin
            pll_reset <= 1'b1;
            clk_en    <= 1'b0;
          end
          default: begin
            state     <= PLL_RST;
            pll_reset <= 1'b1;
            busy      <= 1'b1;
            clk_en    <= 1'b0;
            cnt       <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl: power-on, reconfigure, lock timeout
// into FAIL, lock glitch in STABLE, lock loss racing a request, and reset
// during WAIT_LOCK. Inputs are driven and outputs sampled 1 time unit after
// each rising edge.
module tb_pll_reconfig_ctrl;

  logic       clk;
  logic       reset;
  logic       req;
  logic [5:0] cfg_idsel;
  logic [5:0] cfg_fbdsel;
  logic [5:0] cfg_odsel;
  logic       ack;
  logic       error;
  logic       busy;
  logic       clk_en;
  logic       lock_lost;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] pll_idsel;
  logic [5:0] pll_fbdsel;
  logic [5:0] pll_odsel;

  int vectors;
  int miscompares;
  int ack_cnt;
  int n;

  pll_reconfig_ctrl #(
    .DEF_IDSEL   (6'd8),
    .DEF_FBDSEL  (6'd15),
    .DEF_ODSEL   (6'd16),
    .RST_CYCLES  (4),
    .LOCK_TIMEOUT(50),
    .LOCK_STABLE (8),
    .GATE_CYCLES (2),
    .MAX_RETRY   (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .cfg_idsel (cfg_idsel),
    .cfg_fbdsel(cfg_fbdsel),
    .cfg_odsel (cfg_odsel),
    .ack       (ack),
    .error     (error),
    .busy      (busy),
    .clk_en    (clk_en),
    .lock_lost (lock_lost),
    .pll_lock  (pll_lock),
    .pll_reset (pll_reset),
    .pll_idsel (pll_idsel),
    .pll_fbdsel(pll_fbdsel),
    .pll_odsel (pll_odsel)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are settled 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
    if (ack === 1'b1) ack_cnt++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Step until the selected output (0 pll_reset, 1 clk_en, 2 ack) equals
  // val; n returns the number of edges taken. An expired budget is a miss.
  task automatic wait_sig(input string tag, input int sel, input logic val,
                          input int budget, output int edges);
    logic cur;
    edges = 0;
    cur   = ~val;
    while (cur !== val && edges < budget) begin
      step();
      edges++;
      case (sel)
        0:       cur = pll_reset;
        1:       cur = clk_en;
        default: cur = ack;
      endcase
    end
    chk({tag, "_reached"}, 32'(cur), 32'(val));
  endtask

  task automatic chk_sel(input string tag, input logic [5:0] i, input logic [5:0] f,
                         input logic [5:0] o);
    chk({tag, "_idsel"},  32'(pll_idsel),  32'(i));
    chk({tag, "_fbdsel"}, 32'(pll_fbdsel), 32'(f));
    chk({tag, "_odsel"},  32'(pll_odsel),  32'(o));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    ack_cnt     = 0;
    reset       = 1'b1;
    req         = 1'b0;
    pll_lock    = 1'b0;
    cfg_idsel   = '0;
    cfg_fbdsel  = '0;
    cfg_odsel   = '0;

    // Power-on
    repeat (3) step();
    chk("rst_pll_reset", 32'(pll_reset), 1);
    chk("rst_clk_en",    32'(clk_en),    0);
    chk("rst_busy",      32'(busy),      1);
    chk("rst_ack",       32'(ack),       0);
    chk("rst_error",     32'(error),     0);
    chk("rst_lock_lost", 32'(lock_lost), 0);
    chk_sel("rst", 6'd8, 6'd15, 6'd16);
    reset = 1'b0;
    wait_sig("por_rst", 0, 1'b0, 20, n);
    chk("por_rst_len", 32'(n), 4);
    repeat (6) step();
    pll_lock = 1'b1;
    wait_sig("por_lock", 1, 1'b1, 40, n);
    chk("por_lock_to_clk_en", 32'(n), 10);
    chk("por_busy", 32'(busy), 0);
    chk_sel("por", 6'd8, 6'd15, 6'd16);
    chk("por_no_ack", 32'(ack_cnt), 0);

    // Reconfigure
    cfg_idsel = 6'd2; cfg_fbdsel = 6'd20; cfg_odsel = 6'd8;
    req = 1'b1;
    step();
    chk("rcfg_accept_busy",   32'(busy),      1);
    chk("rcfg_accept_clk_en", 32'(clk_en),    0);
    chk("rcfg_accept_reset",  32'(pll_reset), 0);
    chk_sel("rcfg_gate", 6'd8, 6'd15, 6'd16);
    wait_sig("rcfg_gate", 0, 1'b1, 10, n);
    chk("rcfg_gate_len", 32'(n), 2);
    chk_sel("rcfg_rst", 6'd2, 6'd20, 6'd8);
    pll_lock = 1'b0;
    repeat (5) step();
    pll_lock = 1'b1;
    wait_sig("rcfg_ack", 2, 1'b1, 40, n);
    chk("rcfg_lock_to_ack", 32'(n), 10);
    chk("rcfg_clk_en", 32'(clk_en), 1);
    chk("rcfg_error",  32'(error),  0);
    req = 1'b0;
    step();
    chk("rcfg_ack_width", 32'(ack), 0);
    chk("rcfg_ack_cnt", 32'(ack_cnt), 1);

    // Lock never arrives
    cfg_idsel = 6'd3; cfg_fbdsel = 6'd10; cfg_odsel = 6'd4;
    req = 1'b1;
    step();
    pll_lock = 1'b0;
    wait_sig("nolock_gate", 0, 1'b1, 10, n);
    chk("nolock_gate_len", 32'(n), 2);
    chk_sel("nolock", 6'd3, 6'd10, 6'd4);
    wait_sig("nolock_rst1", 0, 1'b0, 20, n);
    chk("nolock_rst1_len", 32'(n), 4);
    wait_sig("nolock_wait1", 0, 1'b1, 80, n);
    chk("nolock_wait1_len", 32'(n), 50);
    wait_sig("nolock_rst2", 0, 1'b0, 20, n);
    chk("nolock_rst2_len", 32'(n), 4);
    wait_sig("nolock_ack", 2, 1'b1, 80, n);
    chk("nolock_wait2_len", 32'(n), 50);
    chk("fail_pll_reset", 32'(pll_reset), 1);
    chk("fail_error",     32'(error),     1);
    chk("fail_clk_en",    32'(clk_en),    0);
    chk("fail_busy",      32'(busy),      0);
    req = 1'b0;
    step();
    chk("fail_ack_width", 32'(ack), 0);
    chk("fail_error_hold", 32'(error), 1);
    chk("fail_ack_cnt", 32'(ack_cnt), 2);

    // Request from FAIL, then lock glitch in STABLE
    cfg_idsel = 6'd5; cfg_fbdsel = 6'd25; cfg_odsel = 6'd2;
    req = 1'b1;
    step();
    chk("fail_accept_busy",  32'(busy),  1);
    chk("fail_accept_error", 32'(error), 0);
    wait_sig("glitch_rst", 0, 1'b0, 20, n);
    chk("glitch_to_wait", 32'(n), 6);
    chk_sel("glitch", 6'd5, 6'd25, 6'd2);
    pll_lock = 1'b1;
    repeat (5) step();
    pll_lock = 1'b0;
    step();
    pll_lock = 1'b1;
    wait_sig("glitch_ack", 2, 1'b1, 40, n);
    chk("glitch_rise2_to_ack", 32'(n), 10);
    chk("glitch_clk_en", 32'(clk_en), 1);
    chk("glitch_error",  32'(error),  0);
    req = 1'b0;
    step();
    chk("glitch_ack_cnt", 32'(ack_cnt), 3);

    // Lock loss racing a request: req reaches the FSM with lock_s = 0
    pll_lock = 1'b0;
    repeat (2) step();
    cfg_idsel = 6'd7; cfg_fbdsel = 6'd30; cfg_odsel = 6'd1;
    req = 1'b1;
    step();
    chk("loss_lock_lost", 32'(lock_lost), 1);
    chk("loss_clk_en",    32'(clk_en),    0);
    chk("loss_pll_reset", 32'(pll_reset), 1);
    chk("loss_busy",      32'(busy),      1);
    chk_sel("loss_old", 6'd5, 6'd25, 6'd2);
    pll_lock = 1'b1;
    wait_sig("loss_relock", 1, 1'b1, 40, n);
    chk("loss_relock_len", 32'(n), 12);
    chk("loss_relock_ack", 32'(ack), 0);
    chk("loss_relock_lost", 32'(lock_lost), 1);
    chk_sel("loss_relock", 6'd5, 6'd25, 6'd2);
    step();
    chk("loss_req_lock_lost", 32'(lock_lost), 0);
    chk("loss_req_busy",      32'(busy),      1);
    wait_sig("loss_req_gate", 0, 1'b1, 10, n);
    chk("loss_req_gate_len", 32'(n), 2);
    chk_sel("loss_req", 6'd7, 6'd30, 6'd1);
    wait_sig("loss_req_ack", 2, 1'b1, 40, n);
    chk("loss_req_rst_to_ack", 32'(n), 12);
    chk("loss_req_error", 32'(error), 0);
    req = 1'b0;
    step();
    chk("loss_ack_cnt", 32'(ack_cnt), 4);

    // Reset during WAIT_LOCK
    cfg_idsel = 6'd9; cfg_fbdsel = 6'd9; cfg_odsel = 6'd9;
    req = 1'b1;
    step();
    pll_lock = 1'b0;
    wait_sig("abort_gate", 0, 1'b1, 10, n);
    wait_sig("abort_rst", 0, 1'b0, 20, n);
    repeat (3) step();
    chk("abort_pre_busy", 32'(busy), 1);
    reset = 1'b1;
    step();
    chk_sel("abort", 6'd8, 6'd15, 6'd16);
    chk("abort_pll_reset", 32'(pll_reset), 1);
    chk("abort_ack",       32'(ack),       0);
    chk("abort_error",     32'(error),     0);
    chk("abort_busy",      32'(busy),      1);
    chk("abort_clk_en",    32'(clk_en),    0);
    reset = 1'b0;
    req   = 1'b0;
    step();
    chk("abort_hold_reset", 32'(pll_reset), 1);
    chk("abort_ack_cnt", 32'(ack_cnt), 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
